// File: rtl/pipe_pkg.sv
// Shared encodings for the ID-stage control unit: opcodes, funcs, ALU ops,
// PC/forwarding selects and the ID/EX control payload.
package pipe_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned FN_W   = 6;
  localparam int unsigned ALUC_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010,
                              OP_JAL   = 6'b000011, OP_BEQ  = 6'b000100,
                              OP_BNE   = 6'b000101, OP_ADDI = 6'b001000,
                              OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101,
                              OP_XORI  = 6'b001110, OP_LUI  = 6'b001111,
                              OP_LW    = 6'b100011, OP_SW   = 6'b101011;

  localparam logic [FN_W-1:0] FN_SLL = 6'b000000, FN_SRL = 6'b000010,
                              FN_SRA = 6'b000011, FN_JR  = 6'b001000,
                              FN_MUL = 6'b011000, FN_ADD = 6'b100000,
                              FN_SUB = 6'b100010, FN_AND = 6'b100100,
                              FN_OR  = 6'b100101, FN_XOR = 6'b100110,
                              FN_CNT = 6'b100111;

  typedef enum logic [ALUC_W-1:0] {
    ALUC_ADD = 4'b0000, ALUC_AND = 4'b0001, ALUC_XOR = 4'b0010,
    ALUC_SLL = 4'b0011, ALUC_SUB = 4'b0100, ALUC_OR  = 4'b0101,
    ALUC_LUI = 4'b0110, ALUC_SRL = 4'b0111, ALUC_CNT = 4'b1000,
    ALUC_MUL = 4'b1011, ALUC_SRA = 4'b1111
  } aluc_e;

  typedef enum logic [1:0] {PC_SEQ = 2'b00, PC_BR = 2'b01, PC_JR = 2'b10, PC_JMP = 2'b11} pcsel_e;

  typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_EXE = 2'b01, FWD_MEM = 2'b10, FWD_LOAD = 2'b11} fwd_e;

  typedef enum logic {MUL_IDLE = 1'b0, MUL_BUSY = 1'b1} mul_state_e;

  // Control bundle carried from ID into EX.
  typedef struct packed {
    logic  wreg;
    logic  m2reg;
    logic  wmem;
    logic  jal;
    logic  aluimm;
    logic  shift;
    aluc_e aluc;
  } ex_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Datapath <-> control-unit bundle: ID fields and MEM hazard info in,
// PC/forwarding selects and registered EX controls out.
interface pipe_ctrl_unit_if
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W = 5
);

  logic [OP_W-1:0] op;
  logic [FN_W-1:0] func;
  logic [RA_W-1:0] rs, rt, rd;
  logic            rsrtequ;
  logic            mwreg, mm2reg;
  logic [RA_W-1:0] mrn;

  pcsel_e            pcsource;
  logic              wpcir, jwait;
  fwd_e              fwda, fwdb;
  logic              regrt, sext;
  logic              ewreg, em2reg, ewmem, ejal, ealuimm, eshift;
  logic [ALUC_W-1:0] ealuc;
  logic [RA_W-1:0]   ern;
  logic              estall;

  modport master (
    output op, func, rs, rt, rd, rsrtequ, mwreg, mm2reg, mrn,
    input  pcsource, wpcir, jwait, fwda, fwdb, regrt, sext,
           ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern, estall
  );

  modport slave (
    input  op, func, rs, rt, rd, rsrtequ, mwreg, mm2reg, mrn,
    output pcsource, wpcir, jwait, fwda, fwdb, regrt, sext,
           ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern, estall
  );

endinterface

// File: rtl/pipe_fwd_sel.sv
// Single-operand forwarding comparator; EX match beats MEM match, r0 never forwards.
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic            ex_en,
  input  logic            ewreg,
  input  logic            em2reg,
  input  logic [RA_W-1:0] ern,
  input  logic            mwreg,
  input  logic            mm2reg,
  input  logic [RA_W-1:0] mrn,
  output fwd_e            fwd_c
);

  always_comb begin
    fwd_c = FWD_REG;
    if (ex_en && ewreg && !em2reg && (ern != '0) && (ern == src)) begin
      fwd_c = FWD_EXE;
    end else if (mwreg && (mrn != '0) && (mrn == src)) begin
      fwd_c = mm2reg ? FWD_LOAD : FWD_MEM;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage decode, hazard detection and ID/EX control register.
// Define CU_MUL_EN to add the multi-cycle mul instruction and its EX-occupancy FSM.
module pipe_ctrl_unit
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W       = 5,
  parameter int unsigned MUL_CYCLES = 4
) (
  input logic             clock,
  input logic             resetn,
  pipe_ctrl_unit_if.slave bus
);

  ex_ctrl_t        id_ctrl, ex_d, ex_q;
  logic [RA_W-1:0] dest, ern_q;
  logic            regrt, sext, uses_rs, uses_rt;
  logic            is_j, is_jal, is_jr, is_beq, is_bne;
  logic            load_use, bubble, squash_q, estall, ex_fwd_en, jwait;
  pcsel_e          pcsel;
`ifdef CU_MUL_EN
  logic            id_mul;
`endif

  // The mul counter cannot express occupancies below two cycles.
  if (MUL_CYCLES < 2) begin : g_mul_cycles_invalid
  end

  // Instruction decode.
  always_comb begin
    id_ctrl = '0;
    regrt   = 1'b0;
    sext    = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
`ifdef CU_MUL_EN
    id_mul  = 1'b0;
`endif
    case (bus.op)
      OP_RTYPE: begin
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
        id_ctrl.wreg = 1'b1;
        case (bus.func)
          FN_ADD: id_ctrl.aluc = ALUC_ADD;
          FN_SUB: id_ctrl.aluc = ALUC_SUB;
          FN_AND: id_ctrl.aluc = ALUC_AND;
          FN_OR:  id_ctrl.aluc = ALUC_OR;
          FN_XOR: id_ctrl.aluc = ALUC_XOR;
          FN_CNT: id_ctrl.aluc = ALUC_CNT;
          FN_SLL: begin id_ctrl.aluc = ALUC_SLL; id_ctrl.shift = 1'b1; uses_rs = 1'b0; end
          FN_SRL: begin id_ctrl.aluc = ALUC_SRL; id_ctrl.shift = 1'b1; uses_rs = 1'b0; end
          FN_SRA: begin id_ctrl.aluc = ALUC_SRA; id_ctrl.shift = 1'b1; uses_rs = 1'b0; end
          FN_JR:  begin id_ctrl.wreg = 1'b0; is_jr = 1'b1; end
`ifdef CU_MUL_EN
          FN_MUL: begin id_ctrl.aluc = ALUC_MUL; id_mul = 1'b1; end
`endif
          default: begin id_ctrl.wreg = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0; end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        id_ctrl.wreg   = 1'b1;
        id_ctrl.aluimm = 1'b1;
        regrt          = 1'b1;
        uses_rs        = 1'b1;
        sext           = (bus.op == OP_ADDI);
        id_ctrl.aluc   = (bus.op == OP_ANDI) ? ALUC_AND :
                         (bus.op == OP_ORI)  ? ALUC_OR  :
                         (bus.op == OP_XORI) ? ALUC_XOR : ALUC_ADD;
      end
      OP_LW: begin
        id_ctrl.wreg   = 1'b1;
        id_ctrl.m2reg  = 1'b1;
        id_ctrl.aluimm = 1'b1;
        regrt          = 1'b1;
        sext           = 1'b1;
        uses_rs        = 1'b1;
      end
      OP_SW: begin
        id_ctrl.wmem   = 1'b1;
        id_ctrl.aluimm = 1'b1;
        sext           = 1'b1;
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        id_ctrl.aluc = ALUC_SUB;
        sext         = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
        is_beq       = (bus.op == OP_BEQ);
        is_bne       = (bus.op == OP_BNE);
      end
      OP_LUI: begin
        id_ctrl.wreg   = 1'b1;
        id_ctrl.aluimm = 1'b1;
        id_ctrl.aluc   = ALUC_LUI;
        regrt          = 1'b1;
      end
      OP_J: is_j = 1'b1;
      OP_JAL: begin
        id_ctrl.wreg = 1'b1;
        id_ctrl.jal  = 1'b1;
        is_jal       = 1'b1;
      end
      default: ;
    endcase
  end

  assign dest = regrt ? bus.rt : (id_ctrl.jal ? '1 : bus.rd);

  assign load_use = ex_q.wreg && ex_q.m2reg && (ern_q != '0) &&
                    ((uses_rs && (ern_q == bus.rs)) || (uses_rt && (ern_q == bus.rt)));
  assign bubble   = load_use || squash_q;

  // Control transfer resolves only when nothing older is stalling ID.
  always_comb begin
    pcsel = PC_SEQ;
    if (!estall && !load_use && !squash_q) begin
      if (is_j || is_jal)                                      pcsel = PC_JMP;
      else if (is_jr)                                          pcsel = PC_JR;
      else if ((is_beq && bus.rsrtequ) || (is_bne && !bus.rsrtequ)) pcsel = PC_BR;
    end
  end

  assign jwait = (pcsel != PC_SEQ);

  always_comb begin
    ex_d = id_ctrl;
    if (bubble) begin
      ex_d.wreg  = 1'b0;
      ex_d.m2reg = 1'b0;
      ex_d.wmem  = 1'b0;
      ex_d.jal   = 1'b0;
    end
  end

  // ID/EX control register and squash flag; both freeze while EX is occupied.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex_q     <= '0;
      ern_q    <= '0;
      squash_q <= 1'b0;
    end else if (!estall) begin
      ex_q  <= ex_d;
      ern_q <= dest;
      if (!load_use) squash_q <= jwait;
    end
  end

`ifdef CU_MUL_EN
  localparam int unsigned CNT_W = $clog2(MUL_CYCLES);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // BUSY covers the MUL_CYCLES-1 cycles after mul is loaded into EX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MUL_IDLE: begin
        if (id_mul && !bubble) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
        end
      end
      MUL_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  assign estall    = (state_q == MUL_BUSY);
  assign ex_fwd_en = !estall;
`else
  assign estall    = 1'b0;
  assign ex_fwd_en = 1'b1;
`endif

  pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_rs (
    .src(bus.rs), .ex_en(ex_fwd_en), .ewreg(ex_q.wreg), .em2reg(ex_q.m2reg), .ern(ern_q),
    .mwreg(bus.mwreg), .mm2reg(bus.mm2reg), .mrn(bus.mrn), .fwd_c(bus.fwda)
  );

  pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_rt (
    .src(bus.rt), .ex_en(ex_fwd_en), .ewreg(ex_q.wreg), .em2reg(ex_q.m2reg), .ern(ern_q),
    .mwreg(bus.mwreg), .mm2reg(bus.mm2reg), .mrn(bus.mrn), .fwd_c(bus.fwdb)
  );

  assign bus.pcsource = pcsel;
  assign bus.jwait    = jwait;
  assign bus.wpcir    = !(estall || load_use);
  assign bus.regrt    = regrt;
  assign bus.sext     = sext;
  assign bus.ewreg    = ex_q.wreg;
  assign bus.em2reg   = ex_q.m2reg;
  assign bus.ewmem    = ex_q.wmem;
  assign bus.ejal     = ex_q.jal;
  assign bus.ealuimm  = ex_q.aluimm;
  assign bus.eshift   = ex_q.shift;
  assign bus.ealuc    = ex_q.aluc;
  assign bus.ern      = ern_q;
  assign bus.estall   = estall;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: forwarding, load-use, squash, jal and
// reset checks, plus mul occupancy when CU_MUL_EN is defined.
module tb_pipe_ctrl_unit;
  import pipe_pkg::*;

  localparam logic [5:0] OP_BAD = 6'b111111;

  logic clock;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  pipe_ctrl_unit_if #(.RA_W(5)) bus ();

  pipe_ctrl_unit #(.RA_W(5), .MUL_CYCLES(4)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic eq);
    bus.op = o; bus.func = f; bus.rs = s; bus.rt = t; bus.rd = d; bus.rsrtequ = eq;
  endtask

  task automatic set_mem(input logic w, input logic m, input logic [4:0] n);
    bus.mwreg = w; bus.mm2reg = m; bus.mrn = n;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    set_id(OP_BAD, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_mem(1'b0, 1'b0, 5'd0);
    #3;
    chk("rst_ewreg", 32'(bus.ewreg), 0);
    chk("rst_ern", 32'(bus.ern), 0);
    chk("rst_estall", 32'(bus.estall), 0);
    chk("rst_wpcir", 32'(bus.wpcir), 1);
    @(negedge clock);
    resetn = 1'b1;

    // add r3,r1,r2
    set_id(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b0); #1;
    chk("add_fwda", 32'(bus.fwda), 0);
    chk("add_pcsrc", 32'(bus.pcsource), 0);
    chk("add_regrt", 32'(bus.regrt), 0);
    tick();
    chk("add_ewreg", 32'(bus.ewreg), 1);
    chk("add_ern", 32'(bus.ern), 3);
    chk("add_ealuc", 32'(bus.ealuc), 0);

    // add r4,r3,r5 : EX forward on rs
    set_id(OP_RTYPE, FN_ADD, 5'd3, 5'd5, 5'd4, 1'b0); #1;
    chk("ex_fwda", 32'(bus.fwda), 1);
    chk("ex_fwdb", 32'(bus.fwdb), 0);
    chk("ex_wpcir", 32'(bus.wpcir), 1);
    tick();

    // lw r3,0(r1) with add r3 in MEM
    set_id(OP_LW, 6'd0, 5'd1, 5'd3, 5'd0, 1'b0); set_mem(1'b1, 1'b0, 5'd3); #1;
    chk("mem_fwdb", 32'(bus.fwdb), 2);
    chk("lw_regrt", 32'(bus.regrt), 1);
    chk("lw_sext", 32'(bus.sext), 1);
    tick();
    chk("lw_em2reg", 32'(bus.em2reg), 1);
    chk("lw_ealuimm", 32'(bus.ealuimm), 1);

    // sub r6,r3,r1 : load-use stall
    set_id(OP_RTYPE, FN_SUB, 5'd3, 5'd1, 5'd6, 1'b0); set_mem(1'b1, 1'b0, 5'd4); #1;
    chk("lu_wpcir", 32'(bus.wpcir), 0);
    chk("lu_fwda", 32'(bus.fwda), 0);
    tick();
    chk("lu_bubble_ewreg", 32'(bus.ewreg), 0);
    set_mem(1'b1, 1'b1, 5'd3); #1;
    chk("lu_fwda_load", 32'(bus.fwda), 3);
    chk("lu_wpcir_rel", 32'(bus.wpcir), 1);
    tick();
    chk("sub_ern", 32'(bus.ern), 6);
    chk("sub_ealuc", 32'(bus.ealuc), 4);

    // beq r6,r7 taken
    set_id(OP_BEQ, 6'd0, 5'd6, 5'd7, 5'd0, 1'b1); set_mem(1'b0, 1'b0, 5'd0); #1;
    chk("beq_pcsrc", 32'(bus.pcsource), 1);
    chk("beq_jwait", 32'(bus.jwait), 1);
    chk("beq_fwda", 32'(bus.fwda), 1);
    tick();
    // jal in the squash slot is ignored
    set_id(OP_JAL, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("sq_pcsrc", 32'(bus.pcsource), 0);
    chk("sq_jwait", 32'(bus.jwait), 0);
    tick();
    chk("sq_ewreg", 32'(bus.ewreg), 0);
    chk("sq_ejal", 32'(bus.ejal), 0);

    // real jal
    #1;
    chk("jal_pcsrc", 32'(bus.pcsource), 3);
    tick();
    chk("jal_ejal", 32'(bus.ejal), 1);
    chk("jal_ern", 32'(bus.ern), 31);
    chk("jal_ewreg", 32'(bus.ewreg), 1);
    set_id(OP_ADDI, 6'd0, 5'd31, 5'd8, 5'd0, 1'b0); #1;
    chk("sq_fwda_valid", 32'(bus.fwda), 1);
    chk("sq_wpcir", 32'(bus.wpcir), 1);
    tick();
    chk("sq2_ewreg", 32'(bus.ewreg), 0);
    tick();
    chk("addi_ern", 32'(bus.ern), 8);
    chk("addi_ewreg", 32'(bus.ewreg), 1);

    // lw r9 then beq on r9: stall must block the branch
    set_id(OP_LW, 6'd0, 5'd1, 5'd9, 5'd0, 1'b0); tick();
    set_id(OP_BEQ, 6'd0, 5'd9, 5'd2, 5'd0, 1'b1); #1;
    chk("lub_pcsrc", 32'(bus.pcsource), 0);
    chk("lub_jwait", 32'(bus.jwait), 0);
    chk("lub_wpcir", 32'(bus.wpcir), 0);
    tick();
    set_mem(1'b1, 1'b1, 5'd9); #1;
    chk("lub2_fwda", 32'(bus.fwda), 3);
    chk("lub2_pcsrc", 32'(bus.pcsource), 1);
    tick();
    set_id(OP_BNE, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0); set_mem(1'b0, 1'b0, 5'd0); #1;
    chk("bne_sq_pcsrc", 32'(bus.pcsource), 0);
    tick();
    set_id(OP_RTYPE, FN_JR, 5'd5, 5'd0, 5'd0, 1'b0); #1;
    chk("jr_pcsrc", 32'(bus.pcsource), 2);
    chk("jr_fwda", 32'(bus.fwda), 0);
    tick();
    set_id(OP_BAD, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0); tick();
    set_id(OP_BAD, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0); tick();
    chk("nop_ewreg", 32'(bus.ewreg), 0);
    chk("nop_ewmem", 32'(bus.ewmem), 0);
    set_id(OP_SW, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0); tick();
    chk("sw_ewmem", 32'(bus.ewmem), 1);

    // r0 never stalls or forwards
    set_id(OP_LW, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0); tick();
    set_id(OP_RTYPE, FN_ADD, 5'd0, 5'd0, 5'd7, 1'b0); set_mem(1'b1, 1'b0, 5'd0); #1;
    chk("r0_wpcir", 32'(bus.wpcir), 1);
    chk("r0_fwda", 32'(bus.fwda), 0);
    tick();

    // shift ignores rs for load-use; EX beats MEM
    set_id(OP_LW, 6'd0, 5'd1, 5'd11, 5'd0, 1'b0); tick();
    set_id(OP_RTYPE, FN_SLL, 5'd11, 5'd4, 5'd12, 1'b0); #1;
    chk("sll_wpcir", 32'(bus.wpcir), 1);
    tick();
    chk("sll_eshift", 32'(bus.eshift), 1);
    set_id(OP_RTYPE, FN_ADD, 5'd12, 5'd0, 5'd13, 1'b0); set_mem(1'b1, 1'b0, 5'd12); #1;
    chk("prio_fwda", 32'(bus.fwda), 1);
    tick();

`ifdef CU_MUL_EN
    set_id(OP_RTYPE, FN_MUL, 5'd1, 5'd2, 5'd12, 1'b0); set_mem(1'b0, 1'b0, 5'd0); tick();
    chk("mul_estall0", 32'(bus.estall), 1);
    chk("mul_ealuc", 32'(bus.ealuc), 11);
    chk("mul_ewreg", 32'(bus.ewreg), 1);
    set_id(OP_RTYPE, FN_ADD, 5'd12, 5'd1, 5'd13, 1'b0); #1;
    chk("mul_wpcir", 32'(bus.wpcir), 0);
    chk("mul_fwda_sup", 32'(bus.fwda), 0);
    tick();
    chk("mul_estall1", 32'(bus.estall), 1);
    chk("mul_ern_hold", 32'(bus.ern), 12);
    tick();
    chk("mul_estall2", 32'(bus.estall), 1);
    tick();
    chk("mul_estall3", 32'(bus.estall), 0);
    chk("mul_ern_last", 32'(bus.ern), 12);
    chk("mul_fwda_last", 32'(bus.fwda), 1);
    tick();
    chk("mul_next_ern", 32'(bus.ern), 13);
    set_id(OP_RTYPE, FN_MUL, 5'd1, 5'd2, 5'd14, 1'b0); tick();
    set_id(OP_BAD, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0); tick();
    chk("mul2_estall", 32'(bus.estall), 1);
`else
    set_id(OP_RTYPE, FN_MUL, 5'd1, 5'd2, 5'd12, 1'b0); set_mem(1'b0, 1'b0, 5'd0); tick();
    chk("nomul_ewreg", 32'(bus.ewreg), 0);
    chk("nomul_estall", 32'(bus.estall), 0);
    set_id(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd14, 1'b0); tick();
    chk("prerst_ewreg", 32'(bus.ewreg), 1);
`endif

    // asynchronous reset mid-instruction
    #2 resetn = 1'b0;
    #1;
    chk("arst_estall", 32'(bus.estall), 0);
    chk("arst_ewreg", 32'(bus.ewreg), 0);
    chk("arst_ern", 32'(bus.ern), 0);
    chk("arst_ealuc", 32'(bus.ealuc), 0);
    @(negedge clock);
    resetn = 1'b1;
    set_id(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd15, 1'b0); #1;
    chk("post_wpcir", 32'(bus.wpcir), 1);
    tick();
    chk("post_ewreg", 32'(bus.ewreg), 1);
    chk("post_ern", 32'(bus.ern), 15);
    chk("post_estall", 32'(bus.estall), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
